// File: rtl/ppu_pixel_fifo_if.sv
// Pixel FIFO bus: tile-row load side, pixel pop side and status.
// master drives loads/pops (fetcher + draw logic); slave is the FIFO itself.
interface ppu_pixel_fifo_if #(
  parameter int BPP    = 2,
  parameter int ROW_PX = 8,
  parameter int DEPTH  = 16
);
  localparam int DW = $clog2(ROW_PX);
  localparam int CW = $clog2(DEPTH + 1);

  logic                    clear;
  logic [DW-1:0]           discard;
  logic                    load_valid;
  logic                    load_ready;
  logic [BPP*ROW_PX-1:0]   load_planes;
  logic [2*(2**BPP)-1:0]   palette;
  logic                    pop;
  logic                    px_valid;
  logic [BPP-1:0]          px_idx;
  logic [1:0]              px_out;
  logic [CW-1:0]           count;
  logic                    empty;
  logic                    underflow;

  modport master (
    output clear, discard, load_valid, load_planes, palette, pop,
    input  load_ready, px_valid, px_idx, px_out, count, empty, underflow
  );

  modport slave (
    input  clear, discard, load_valid, load_planes, palette, pop,
    output load_ready, px_valid, px_idx, px_out, count, empty, underflow
  );
endinterface

// File: rtl/ppu_pixel_fifo.sv
// Planar tile-row in, one palette-mapped pixel out per pop, with scanline flush.
// Define PPU_FIFO_DISCARD_EN to enable fine-scroll discard of leading pixels.
module ppu_pixel_fifo #(
  parameter int BPP    = 2,
  parameter int ROW_PX = 8,
  parameter int DEPTH  = 16
) (
  input logic             clk,
  input logic             rst,
  ppu_pixel_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DISCARD = 2'd1;
  localparam logic [1:0] STREAM  = 2'd2;

  logic [1:0]     state;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [BPP-1:0] mem [DEPTH];

  logic           px_valid_p1;
  logic           underflow_p1;
  logic [BPP-1:0] px_idx_p1;
  logic [1:0]     px_out_p1;

  logic load_ready;
  logic load_acc;
  logic rd_en;
  logic drop_en;
  logic adv;

  function automatic logic [BPP-1:0] row_idx(input logic [BPP*ROW_PX-1:0] planes, input int k);
    logic [BPP-1:0] idx;
    for (int p = 0; p < BPP; p++) idx[p] = planes[p*ROW_PX + ROW_PX-1-k];
    return idx;
  endfunction

  function automatic logic [1:0] shade(input logic [2*(2**BPP)-1:0] pal, input logic [BPP-1:0] idx);
    return pal[2*idx +: 2];
  endfunction

  // Space is judged on registered count only so pop never reaches load_ready.
  assign load_ready = (count <= CW'(DEPTH - ROW_PX)) && !bus.clear;
  assign load_acc   = bus.load_valid && load_ready;
  assign rd_en      = (state == STREAM) && bus.pop && (count != '0) && !bus.clear;
  assign adv        = rd_en || drop_en;

`ifdef PPU_FIFO_DISCARD_EN
  localparam int DW = $clog2(ROW_PX);
  logic [DW-1:0] disc_cnt;
  assign drop_en = (state == DISCARD) && (count != '0) && !bus.clear;
`else
  logic unused_discard;
  assign unused_discard = ^bus.discard;
  assign drop_en = 1'b0;
`endif

  // Stage p0 -> p1: pointer/count/FSM update and registered pixel output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      px_valid_p1  <= 1'b0;
      underflow_p1 <= 1'b0;
      px_idx_p1    <= '0;
      px_out_p1    <= '0;
`ifdef PPU_FIFO_DISCARD_EN
      disc_cnt     <= '0;
`endif
    end else if (bus.clear) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      px_valid_p1  <= 1'b0;
      underflow_p1 <= 1'b0;
`ifdef PPU_FIFO_DISCARD_EN
      disc_cnt     <= bus.discard;
`endif
    end else begin
      if (load_acc) wr_ptr <= wr_ptr + AW'(ROW_PX);
      if (adv)      rd_ptr <= rd_ptr + AW'(1);
      count <= count + (load_acc ? CW'(ROW_PX) : CW'(0)) - (adv ? CW'(1) : CW'(0));
      px_valid_p1  <= rd_en;
      underflow_p1 <= (state == STREAM) && bus.pop && (count == '0);
      if (rd_en) begin
        px_idx_p1 <= mem[rd_ptr];
        px_out_p1 <= shade(bus.palette, mem[rd_ptr]);
      end
      case (state)
        IDLE: begin
          if (load_acc) begin
`ifdef PPU_FIFO_DISCARD_EN
            state <= (disc_cnt != '0) ? DISCARD : STREAM;
`else
            state <= STREAM;
`endif
          end
        end
        DISCARD: begin
`ifdef PPU_FIFO_DISCARD_EN
          if (drop_en) begin
            disc_cnt <= disc_cnt - DW'(1);
            if (disc_cnt == DW'(1)) state <= STREAM;
          end
`else
          state <= STREAM;
`endif
        end
        STREAM:  state <= STREAM;
        default: state <= IDLE;
      endcase
    end
  end

  // Row storage: leftmost pixel lands at wr_ptr, no reset on data
  always_ff @(posedge clk) begin
    if (load_acc) begin
      for (int k = 0; k < ROW_PX; k++) mem[wr_ptr + AW'(k)] <= row_idx(bus.load_planes, k);
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.px_valid   = px_valid_p1;
  assign bus.px_idx     = px_idx_p1;
  assign bus.px_out     = px_out_p1;
  assign bus.count      = count;
  assign bus.empty      = (count == '0);
  assign bus.underflow  = underflow_p1;
endmodule

// File: doc/ppu_pixel_fifo.md
# ppu_pixel_fifo

Parametrised pixel FIFO for the PPU draw pipeline, replacing the fixed 8-pixel, 2-bitplane background shift register. It accepts whole planar tile rows from the tile fetcher and streams one pixel per pop. Each pixel leaves as a raw colour index plus a palette-mapped 2-bit shade. It supports a per-scanline flush and, optionally, a fine-scroll discard of the leading pixels.

## Interface
- BPP, default 2: bits per pixel, which is also the number of bitplanes per row.
- ROW_PX, default 8: pixels per loaded tile row.
- DEPTH, default 16: FIFO capacity in pixels. Must be a power of two and at least 2*ROW_PX.
- clk  in  1: clock.
- rst  in  1: asynchronous, active-high reset.
- clear  in  1: synchronous flush at scanline start.
- discard  in  $clog2(ROW_PX): number of leading pixels to drop after a clear (SCX mod 8). Sampled on clear.
- load_valid  in  1: fetcher presents a row.
- load_ready  out  1: FIFO has room for one full row.
- load_planes  in  BPP*ROW_PX: plane p occupies bits [p*ROW_PX +: ROW_PX]. Bit ROW_PX-1 is the leftmost pixel.
- palette  in  2*2**BPP: shade for index i is palette[2*i +: 2] (the BGP layout when BPP=2).
- pop  in  1: request one pixel.
- px_valid  out  1: px_idx and px_out carry a popped pixel this cycle.
- px_idx  out  BPP: raw colour index.
- px_out  out  2: palette-mapped shade.
- count  out  $clog2(DEPTH+1): pixels currently stored.
- empty  out  1: count == 0.
- underflow  out  1: one-cycle pulse when pop is asserted while count == 0 in STREAM.

## Operation
- Storage: a circular buffer of DEPTH entries, BPP bits each. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Load handshake: a row is accepted when load_valid && load_ready && !clear.
  - The row writes ROW_PX entries, leftmost first.
  - Entry k gets index {plane[BPP-1][ROW_PX-1-k], …, plane[0][ROW_PX-1-k]}.
- load_ready = (count <= DEPTH-ROW_PX) && !clear. It is computed from registered count only, with no combinational path from pop.
- FSM states are IDLE, DISCARD and STREAM.
  - IDLE is entered on reset or clear. When the first row is accepted, the next state is DISCARD if disc_cnt != 0, otherwise STREAM.
  - In DISCARD, while count > 0, one pixel is dropped per cycle: rd_ptr advances and disc_cnt decrements. px_valid stays 0 and pop is ignored. The FSM goes to STREAM in the cycle disc_cnt reaches 0.
  - In STREAM, pop with count > 0 reads one entry.
- Simultaneous load and read or drop in the same cycle are both performed: count += ROW_PX-1.
- clear has the highest priority below rst. It zeroes pointers and count, loads disc_cnt from discard, returns to IDLE, and drops any concurrent load or pop.
- Pop while in IDLE is ignored and does not raise underflow.

## Timing
- Reset values: load_ready=1, px_valid=0, px_idx=0, px_out=0, count=0, empty=1, underflow=0, state IDLE, pointers 0, disc_cnt 0.
- Read latency is 1 cycle: a pop accepted at edge N gives px_valid, px_idx and px_out registered at N+1.
- px_out is registered together with px_idx, using the palette value at the pop cycle.
- count and empty are registered and update on the edge after a load or read.
- load_ready deasserts in the cycle after the accepting edge if space drops below ROW_PX.
- A full-rate pop stream, with a row loaded every ROW_PX cycles and DEPTH=2*ROW_PX, never underflows once the first row is in.
- rst asserted mid-operation forces all reset values immediately (asynchronous). The first edge after deassertion behaves as IDLE.

## Configuration
- Macro PPU_FIFO_DISCARD_EN.
- Defined: discard input and the DISCARD state are active as described above.
- Undefined: the discard input is ignored, disc_cnt is not implemented, and IDLE always transitions directly to STREAM.

## Test plan
- Basic order: reset, then load planes p1=8'hF0, p0=8'hAA, BPP=2, palette=8'hE4, then pop 8 cycles.
  - Required px_idx sequence is 3,2,3,2,1,0,1,0.
  - px_out equals px_idx.
  - count goes 8→0 and empty rises.
- Backpressure: load two rows without popping.
  - count=16 and load_ready=0.
  - A third load_valid is not accepted until 8 pops have been performed.
- Simultaneous load and pop with count=8: count becomes 15 next cycle and pixel order is preserved across the pointer wrap.
- Discard (macro defined): clear with discard=3, then load p1=0, p0=8'b10110001, then pop continuously.
  - 3 pixels are dropped with px_valid low.
  - Then px_idx is 1,0,0,0,1.
- Clear mid-stream: with count=11, assert clear together with load_valid and pop.
  - count=0 next cycle, the load is not accepted and no px_valid is produced.
- Underflow and async reset: pop on empty in STREAM gives a single underflow pulse. rst asserted mid-pop clears px_valid and count with no clock edge.
